// File: rtl/training_data_feeder.sv
// Training-sample server for distance_calculator: stores samples and labels, presents them chunk by chunk.
// Optional macro FEEDER_LOOP_EN adds a 'loop' input that restarts from sample 0 after the last sample.
module training_data_feeder #(
   parameter int M            = 4,
   parameter int N            = 4,
   parameter int W            = 8,
   parameter int MAX_ELEMENTS = 4,
   parameter int TYPE_W       = 2,
   parameter int NUM_SAMPLES  = 8,
   localparam int ELEMS       = M * N,
   localparam int CHUNKS      = (ELEMS + MAX_ELEMENTS - 1) / MAX_ELEMENTS,
   localparam int ADDR_W      = $clog2(NUM_SAMPLES * ELEMS),
   localparam int SAMP_W      = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
`ifdef FEEDER_LOOP_EN
   input  logic                      loop,
`endif
   input  logic                      load_en,
   input  logic [ADDR_W-1:0]         load_addr,
   input  logic [W-1:0]              load_data,
   input  logic                      type_load_en,
   input  logic [SAMP_W-1:0]         type_addr,
   input  logic [TYPE_W-1:0]         type_data,
   input  logic                      start,
   input  logic                      data_request,
   input  logic                      done,
   output logic [W*MAX_ELEMENTS-1:0] training_data,
   output logic [TYPE_W-1:0]         training_data_type,
   output logic                      ready,
   output logic                      busy,
   output logic                      all_done
);

   localparam int TOTAL   = NUM_SAMPLES * ELEMS;
   localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int EL_W    = (MAX_ELEMENTS > 1) ? $clog2(MAX_ELEMENTS) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_PRESENT = 2'd2,
      S_WAIT    = 2'd3
   } state_t;

   state_t                    state_r;
   logic [SAMP_W-1:0]         sample_r;
   logic [CHUNK_W-1:0]        chunk_r;
   logic [EL_W-1:0]           elem_r;
   logic [W*MAX_ELEMENTS-1:0] hold_r;
   logic [W*MAX_ELEMENTS-1:0] hold_next_s;
   logic [W-1:0]              elem_mem_r [TOTAL];
   logic [TYPE_W-1:0]         type_mem_r [NUM_SAMPLES];

   int                        chunk_idx_s;
   logic                      in_range_s;
   logic [ADDR_W-1:0]         rd_addr_s;
   logic [W-1:0]              rd_data_s;
   logic                      last_sample_s;
   logic                      last_chunk_s;
   logic                      last_elem_s;
   logic                      loop_s;

`ifdef FEEDER_LOOP_EN
   assign loop_s = loop;
`else
   assign loop_s = 1'b0;
`endif

   assign last_sample_s = (sample_r == SAMP_W'(NUM_SAMPLES - 1));
   assign last_chunk_s  = (chunk_r == CHUNK_W'(CHUNKS - 1));
   assign last_elem_s   = (elem_r == EL_W'(MAX_ELEMENTS - 1));

   // Element read path: positions past the end of the sample read as zero padding
   always_comb begin
      chunk_idx_s = int'(chunk_r) * MAX_ELEMENTS + int'(elem_r);
      in_range_s  = (chunk_idx_s < ELEMS);
      rd_addr_s   = ADDR_W'(int'(sample_r) * ELEMS + chunk_idx_s);
      if (in_range_s) begin
         rd_data_s = elem_mem_r[rd_addr_s];
      end else begin
         rd_data_s = {W{1'b0}};
      end
      hold_next_s = hold_r;
      hold_next_s[int'(elem_r)*W +: W] = rd_data_s;
   end

   // Loader write port; memories survive reset and are writable only while idle
   always_ff @(posedge clk) begin
      if ((state_r == S_IDLE) && load_en && (int'(load_addr) < TOTAL)) begin
         elem_mem_r[load_addr] <= load_data;
      end
      if ((state_r == S_IDLE) && type_load_en && (int'(type_addr) < NUM_SAMPLES)) begin
         type_mem_r[type_addr] <= type_data;
      end
   end

   // Serving FSM with registered handshake outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r            <= S_IDLE;
         sample_r           <= {SAMP_W{1'b0}};
         chunk_r            <= {CHUNK_W{1'b0}};
         elem_r             <= {EL_W{1'b0}};
         hold_r             <= {(W*MAX_ELEMENTS){1'b0}};
         training_data      <= {(W*MAX_ELEMENTS){1'b0}};
         training_data_type <= {TYPE_W{1'b0}};
         ready              <= 1'b0;
         busy               <= 1'b0;
         all_done           <= 1'b0;
      end else begin
         ready    <= 1'b0;
         all_done <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  sample_r <= {SAMP_W{1'b0}};
                  chunk_r  <= {CHUNK_W{1'b0}};
                  elem_r   <= {EL_W{1'b0}};
                  busy     <= 1'b1;
                  state_r  <= S_FETCH;
               end
            end
            S_FETCH: begin
               hold_r <= hold_next_s;
               if (last_elem_s) begin
                  elem_r             <= {EL_W{1'b0}};
                  training_data      <= hold_next_s;
                  training_data_type <= type_mem_r[sample_r];
                  ready              <= 1'b1;
                  state_r            <= S_PRESENT;
               end else begin
                  elem_r <= elem_r + EL_W'(1);
               end
            end
            S_PRESENT: begin
               state_r <= S_WAIT;
            end
            S_WAIT: begin
               if (done) begin
                  chunk_r <= {CHUNK_W{1'b0}};
                  elem_r  <= {EL_W{1'b0}};
                  if (!last_sample_s) begin
                     sample_r <= sample_r + SAMP_W'(1);
                     state_r  <= S_FETCH;
                  end else begin
                     all_done <= 1'b1;
                     sample_r <= {SAMP_W{1'b0}};
                     if (loop_s) begin
                        state_r <= S_FETCH;
                     end else begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                     end
                  end
               end else if (data_request && !last_chunk_s) begin
                  chunk_r <= chunk_r + CHUNK_W'(1);
                  elem_r  <= {EL_W{1'b0}};
                  state_r <= S_FETCH;
               end
            end
            default: begin
               busy    <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule
